// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bus transaction, load formatting and write-back pass-through
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ramOp_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] storeData_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  input  logic [1:0]  writeHILO_i,
  input  logic [31:0] HI_data_i,
  input  logic [31:0] LO_data_i,
  input  logic [5:0]  stall,
  output logic        stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  writeAddr_o,
  output logic        writeEnable_o,
  output logic [31:0] writeData_o,
  output logic [1:0]  writeHILO_o,
  output logic [31:0] HI_data_o,
  output logic [31:0] LO_data_o,
  output logic        exc_misalign_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw;
  logic w_load, w_store, w_byte, w_half, w_word, w_misalign, w_start, w_unused;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_lb  = ramOp_i == 4'b0001;
  assign w_lbu = ramOp_i == 4'b0010;
  assign w_lh  = ramOp_i == 4'b0011;
  assign w_lhu = ramOp_i == 4'b0100;
  assign w_lw  = ramOp_i == 4'b0101;
  assign w_sb  = ramOp_i == 4'b0110;
  assign w_sh  = ramOp_i == 4'b0111;
  assign w_sw  = ramOp_i == 4'b1000;
  assign w_load  = w_lb | w_lbu | w_lh | w_lhu | w_lw;
  assign w_store = w_sb | w_sh | w_sw;
  assign w_byte  = w_lb | w_lbu | w_sb;
  assign w_half  = w_lh | w_lhu | w_sh;
  assign w_word  = w_lw | w_sw;
  // Only the MEM/WB stall bit matters here; the rest of the vector belongs to other stages
  assign w_unused = ^{stall[5], stall[3:0]};
  assign w_misalign = (w_half & addr_i[0]) | (w_word & |addr_i[1:0]);
  assign w_start    = r_state == IDLE && (w_load | w_store) && !w_misalign;
  assign w_be    = w_word ? 4'b1111 : w_half ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_i[1:0];
  assign w_wdata = w_byte ? {4{storeData_i[7:0]}} : w_half ? {2{storeData_i[15:0]}} : storeData_i;
  assign w_b = addr_i[1] ? (addr_i[0] ? bus_rdata_i[31:24] : bus_rdata_i[23:16])
                         : (addr_i[0] ? bus_rdata_i[15:8]  : bus_rdata_i[7:0]);
  assign w_h = addr_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  assign w_ldata = w_lb  ? {{24{w_b[7]}}, w_b} :
                   w_lbu ? {24'b0, w_b} :
                   w_lh  ? {{16{w_h[15]}}, w_h} :
                   w_lhu ? {16'b0, w_h} : bus_rdata_i;
  assign exc_misalign_o = w_misalign;
  assign stall_req_o    = w_start || r_state == BUSY;
  assign writeData_o    = (r_state == DONE && w_load) ? r_rdata : addr_i;
  assign writeEnable_o  = writeEnable_i && !w_misalign && !stall_req_o && !(r_state == DONE && r_err);
  assign writeAddr_o = writeAddr_i;
  assign writeHILO_o = writeHILO_i;
  assign HI_data_o   = HI_data_i;
  assign LO_data_o   = LO_data_i;
  // Transaction FSM: launch on an aligned memory op, wait for ack or timeout, hold result until MEM/WB takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          bus_addr_o  <= {addr_i[31:2], 2'b00};
          bus_be_o    <= w_be;
          bus_we_o    <= w_store;
          bus_wdata_o <= w_wdata;
          bus_req_o   <= 1'b1;
          r_cnt       <= '0;
          r_err       <= 1'b0;
          r_state     <= BUSY;
        end
        BUSY: if (bus_ack_i) begin
          r_rdata   <= w_ldata;
          bus_req_o <= 1'b0;
          r_state   <= DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_req_o <= 1'b0;
          bus_err_o <= 1'b1;
          r_err     <= 1'b1;
          r_state   <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: if (!stall[4]) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  localparam int T = 4;
  logic        clk = 0, rst = 1;
  logic [3:0]  ramOp_i = 0;
  logic [31:0] addr_i = 0, storeData_i = 0, HI_data_i = 0, LO_data_i = 0, bus_rdata_i = 0;
  logic [4:0]  writeAddr_i = 0;
  logic        writeEnable_i = 0, bus_ack_i = 0;
  logic [1:0]  writeHILO_i = 0;
  logic [5:0]  stall = 0;
  logic        stall_req_o, bus_req_o, bus_we_o, writeEnable_o, exc_misalign_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, writeData_o, HI_data_o, LO_data_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  writeAddr_o;
  logic [1:0]  writeHILO_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ramOp_i(ramOp_i), .addr_i(addr_i), .storeData_i(storeData_i),
    .writeAddr_i(writeAddr_i), .writeEnable_i(writeEnable_i), .writeHILO_i(writeHILO_i),
    .HI_data_i(HI_data_i), .LO_data_i(LO_data_i), .stall(stall), .stall_req_o(stall_req_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .writeAddr_o(writeAddr_o), .writeEnable_o(writeEnable_o), .writeData_o(writeData_o),
    .writeHILO_o(writeHILO_o), .HI_data_o(HI_data_o), .LO_data_o(LO_data_o),
    .exc_misalign_o(exc_misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] wd;
    bit          wd_dc;
    logic        we, mis;
    int          stalls, errs;
    logic [4:0]  wa;
    logic [1:0]  hilo;
    logic [31:0] hi, lo;
  } exp_t;
  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        we;
    int          delay;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0, errors = 0, stall_cnt = 0, err_cnt = 0;
  bit    mon_en = 0, resp_en = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Load result from the lane rules: pick byte/halfword by address, extend per opcode
  function automatic logic [31:0] fmt(input logic [3:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b = 8'(rd >> (8 * int'(a)));
    logic [15:0] h = 16'(rd >> (16 * int'(a[1])));
    case (op)
      4'd1:    return int'($signed(b));
      4'd2:    return 32'(b);
      4'd3:    return int'($signed(h));
      4'd4:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  // delay >= 0: ack asserted in that BUSY cycle (0 = first); delay < 0: never ack
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic we, input logic [31:0] rd, input int delay);
    exp_t  e;
    plan_t p;
    bit    ld, st, mis, done;
    int    sz;
    ld  = op >= 1 && op <= 5;
    st  = op >= 6 && op <= 8;
    sz  = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : (op == 5 || op == 8) ? 4 : 0;
    mis = (ld || st) && sz > 1 && (int'(addr[1:0]) % sz) != 0;
    ramOp_i = op; addr_i = addr; storeData_i = sd; writeEnable_i = we;
    writeAddr_i = 5'($urandom); writeHILO_i = 2'($urandom); HI_data_i = $urandom; LO_data_i = $urandom;
    e.wa = writeAddr_i; e.hilo = writeHILO_i; e.hi = HI_data_i; e.lo = LO_data_i;
    e.mis = mis; e.wd = addr; e.wd_dc = 0; e.we = mis ? 1'b0 : we; e.stalls = 0; e.errs = 0;
    if ((ld || st) && !mis) begin
      p.addr  = addr & ~32'h3;
      p.be    = sz == 4 ? 4'hf : sz == 2 ? 4'(3 << (2 * int'(addr[1]))) : 4'(1 << int'(addr[1:0]));
      p.we    = st;
      p.wdata = sz == 1 ? sd[7:0] * 32'h01010101 : sz == 2 ? sd[15:0] * 32'h00010001 : sd;
      p.rdata = rd;
      p.delay = delay;
      plan_q.push_back(p);
      if (delay < 0) begin
        e.we = 0; e.wd_dc = ld; e.errs = 1; e.stalls = 1 + T;
      end else begin
        e.stalls = 2 + delay;
        if (ld) e.wd = fmt(op, addr[1:0], rd);
      end
    end
    exp_q.push_back(e);
    stall[4] = ($urandom_range(0, 3) == 0);
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!stall_req_o && !stall[4]) done = 1;
      else begin
        @(posedge clk); #1;
        stall[4] = ($urandom_range(0, 3) == 0);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL retire_timeout: got no retirement, expected one within 200 cycles (op %h addr %h)", op, addr);
    end
    @(posedge clk); #1;
    stall[4] = 0;
  endtask

  // Monitor: every cycle the instruction leaves MEM, compare against the oldest expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      if (stall_req_o) stall_cnt++;
      if (bus_err_o) err_cnt++;
      if (!stall_req_o && !stall[4]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: got retirement, expected none (writeData %h)", writeData_o);
        end else begin
          e = exp_q.pop_front();
          if (!e.wd_dc) chk("writeData", writeData_o, e.wd);
          chk("writeEnable", 32'(writeEnable_o), 32'(e.we));
          chk("misalign", 32'(exc_misalign_o), 32'(e.mis));
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          chk("bus_err_pulses", 32'(err_cnt), 32'(e.errs));
          chk("wa_hilo", 32'({writeAddr_o, writeHILO_o}), 32'({e.wa, e.hilo}));
          chk("HI", HI_data_o, e.hi);
          chk("LO", LO_data_o, e.lo);
        end
        stall_cnt = 0;
        err_cnt = 0;
      end
    end
  end

  // Bus responder: check each request against the plan, then ack after the planned delay
  initial forever begin
    plan_t p;
    @(posedge clk); #1;
    if (resp_en && bus_req_o) begin
      if (plan_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bus_req: got request at %h, expected none", bus_addr_o);
        repeat (T + 1) @(posedge clk);
      end else begin
        p = plan_q.pop_front();
        chk("bus_addr", bus_addr_o, p.addr);
        chk("bus_be", 32'(bus_be_o), 32'(p.be));
        chk("bus_we", 32'(bus_we_o), 32'(p.we));
        if (p.we) chk("bus_wdata", bus_wdata_o, p.wdata);
        if (p.delay >= 0) begin
          repeat (p.delay) begin @(posedge clk); #1; end
          bus_rdata_i = p.rdata;
          bus_ack_i = 1;
          @(posedge clk); #1;
          chk("req_drop_ack", 32'(bus_req_o), 0);
          if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
          bus_ack_i = 0;
          bus_rdata_i = $urandom;
        end else begin
          repeat (T) begin @(posedge clk); #1; end
          chk("req_drop_timeout", 32'(bus_req_o), 0);
          chk("bus_err_timeout", 32'(bus_err_o), 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    addr_i = 32'h5555_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req_o), 0);
    chk("rst_bus_we", 32'(bus_we_o), 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_be", 32'(bus_be_o), 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_bus_err", 32'(bus_err_o), 0);
    chk("rst_stall_req", 32'(stall_req_o), 0);
    rst = 0;
    mon_en = 1;
    issue(4'd5, 32'h100, 0, 1, 32'hDEADBEEF, 0);
    issue(4'd1, 32'h203, 0, 1, 32'h80FF0000, 0);
    issue(4'd2, 32'h203, 0, 1, 32'h80FF0000, 1);
    issue(4'd7, 32'h302, 32'h1234ABCD, 0, $urandom, 0);
    issue(4'd5, 32'h101, 0, 1, 0, 0);
    issue(4'd5, 32'h400, 0, 1, 0, -1);
    issue(4'd3, 32'h502, 0, 1, 32'h80017FFF, T - 1);
    issue(4'd6, 32'h603, 32'h000000A5, 0, 0, 2);
    issue(4'd4, 32'h702, 0, 1, 32'h9ABC1234, 0);
    issue(4'd8, 32'h804, 32'hCAFEF00D, 0, 0, 1);
    issue(4'd11, 32'h901, 0, 1, 0, 0);
    for (int i = 0; i < 150; i++)
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom), $urandom,
            ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T - 1)));
    chk("queues_drained", 32'(exp_q.size() + plan_q.size()), 0);
    mon_en = 0;
    resp_en = 0;
    ramOp_i = 4'd5; addr_i = 32'h700; writeEnable_i = 1;
    @(posedge clk); #1;
    chk("pre_reset_busy_req", 32'(bus_req_o), 1);
    rst = 1;
    ramOp_i = 4'd0;
    @(posedge clk); #1;
    rst = 0;
    chk("reset_req_drop", 32'(bus_req_o), 0);
    chk("reset_err", 32'(bus_err_o), 0);
    bus_rdata_i = 32'h12345678;
    bus_ack_i = 1;
    @(negedge clk);
    chk("reset_stall_req", 32'(stall_req_o), 0);
    chk("reset_writeData", writeData_o, 32'h700);
    @(posedge clk); #1;
    bus_ack_i = 0;
    chk("late_ack_req", 32'(bus_req_o), 0);
    @(negedge clk);
    chk("late_ack_stall", 32'(stall_req_o), 0);
    chk("late_ack_writeData", writeData_o, 32'h700);
    @(posedge clk); #1;
    resp_en = 1;
    mon_en = 1;
    issue(4'd5, 32'h104, 0, 1, 32'h0BADF00D, 0);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
